// File: rtl/div_iter_if.sv
// Handshake/operand bundle between the hazard/execute logic (master) and div_iter (slave).
interface div_iter_if #(
  parameter int DW = 32
);
  logic          start_i;
  logic          signed_i;
  logic [DW-1:0] dividend_i;
  logic [DW-1:0] divisor_i;
  logic          annul_i;
  logic [2*DW-1:0] result_o;
  logic          ready_o;
  logic          busy_o;

  modport master (
    output start_i, signed_i, dividend_i, divisor_i, annul_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  start_i, signed_i, dividend_i, divisor_i, annul_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/div_iter.sv
// Radix-2 restoring divider for MIPS DIV/DIVU; result_o = {remainder (HI), quotient (LO)}.
// Optional DIV_EARLY_OUT_EN: finish immediately when |divisor| > |dividend|.
module div_iter #(
  parameter int DW    = 32,
  parameter int CNT_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  div_iter_if.slave  io_div
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ZERO,
    S_RUN,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DW-1:0]     r_rem;
  logic [DW-1:0]     r_quo;
  logic [DW-1:0]     r_dvs;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [2*DW-1:0]   r_result;
  logic              r_ready;
  logic              r_busy;

  logic              w_dvd_neg;
  logic              w_dvs_neg;
  logic [DW-1:0]     w_dvd_mag;
  logic [DW-1:0]     w_dvs_mag;
  logic [DW:0]       w_shift;
  logic [DW:0]       w_diff;
  logic [DW-1:0]     w_rem_nx;
  logic [DW-1:0]     w_quo_nx;
  logic [DW-1:0]     w_rem_fix;
  logic [DW-1:0]     w_quo_fix;
  logic              w_last;

  assign w_dvd_neg = io_div.signed_i & io_div.dividend_i[DW-1];
  assign w_dvs_neg = io_div.signed_i & io_div.divisor_i[DW-1];
  assign w_dvd_mag = w_dvd_neg ? -io_div.dividend_i : io_div.dividend_i;
  assign w_dvs_mag = w_dvs_neg ? -io_div.divisor_i  : io_div.divisor_i;

  // r_quo starts as the dividend magnitude and fills with quotient bits from the LSB
  assign w_shift  = {r_rem, r_quo[DW-1]};
  assign w_diff   = w_shift - {1'b0, r_dvs};
  assign w_rem_nx = w_diff[DW] ? w_shift[DW-1:0] : w_diff[DW-1:0];
  assign w_quo_nx = {r_quo[DW-2:0], ~w_diff[DW]};

  assign w_quo_fix = r_neg_q ? -w_quo_nx : w_quo_nx;
  assign w_rem_fix = r_neg_r ? -w_rem_nx : w_rem_nx;
  assign w_last    = (r_cnt == CNT_W'(DW-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (io_div.start_i && !io_div.annul_i) begin
            r_rem   <= '0;
            r_quo   <= w_dvd_mag;
            r_dvs   <= w_dvs_mag;
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
            r_cnt   <= '0;
            if (io_div.divisor_i == '0) begin
              r_state <= S_ZERO;
              r_busy  <= 1'b1;
            end
`ifdef DIV_EARLY_OUT_EN
            else if (w_dvs_mag > w_dvd_mag) begin
              r_state  <= S_DONE;
              r_result <= {io_div.dividend_i, {DW{1'b0}}};
            end
`endif
            else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        S_ZERO: begin
          if (io_div.annul_i) begin
            r_state <= S_IDLE;
          end else begin
            r_state  <= S_DONE;
            r_result <= '0;
          end
        end
        S_RUN: begin
          if (io_div.annul_i) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_state  <= S_DONE;
              r_result <= {w_rem_fix, w_quo_fix};
            end else begin
              r_busy <= 1'b1;
            end
          end
        end
        S_DONE: begin
          // ready is raised one edge after DONE entry and only while the request is still held
          if (io_div.annul_i || !io_div.start_i) begin
            r_state <= S_IDLE;
          end else begin
            r_ready <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_div.result_o = r_result;
  assign io_div.ready_o  = r_ready;
  assign io_div.busy_o   = r_busy;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: arithmetic reference model plus per-cycle compare of ready/busy/result.
module tb_div_iter;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  bit          chk_en = 1'b0;
  bit          exp_active = 1'b0;
  int          exp_e0 = 0;
  int          exp_lat = 0;
  logic [63:0] exp_res = '0;
  logic [63:0] hold_res = '0;

  div_iter_if #(.DW(DW)) bus ();

  div_iter #(.DW(DW), .CNT_W(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_div (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  function automatic int lat(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    ma = s ? longint'($signed(a)) : longint'({32'd0, a});
    mb = s ? longint'($signed(b)) : longint'({32'd0, b});
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (mb > ma) return 1;
`endif
    return DW + 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin : cmp_p
    logic        e_rdy, e_bsy;
    logic [63:0] e_res;
    if (chk_en) begin
      if (exp_active) begin
        e_rdy = (cyc == exp_e0 + exp_lat);
        e_bsy = (cyc >= exp_e0) && (cyc <= exp_e0 + exp_lat - 2);
        e_res = (cyc >= exp_e0 + exp_lat - 1) ? exp_res : hold_res;
      end else begin
        e_rdy = 1'b0;
        e_bsy = 1'b0;
        e_res = hold_res;
      end
      chk("ready_o", {63'd0, bus.ready_o}, {63'd0, e_rdy});
      chk("busy_o",  {63'd0, bus.busy_o},  {63'd0, e_bsy});
      chk("result_o", bus.result_o, e_res);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    bus.start_i    = 1'b1;
    bus.annul_i    = 1'b0;
    bus.signed_i   = s;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    exp_e0     = cyc + 1;
    exp_lat    = lat(s, a, b);
    exp_res    = model(s, a, b);
    exp_active = 1'b1;
  endtask

  // Hazard-unit behaviour: hold start until ready, then drop it before the next edge
  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b, input bit scramble,
                         output logic [63:0] got, output int took);
    bit ok;
    launch(s, a, b);
    ok   = 1'b0;
    got  = '0;
    took = -1;
    for (int i = 0; i < 80 && !ok; i++) begin
      tick();
      if (scramble) begin
        bus.dividend_i = $urandom;
        bus.divisor_i  = $urandom;
        bus.signed_i   = 1'($urandom_range(0, 1));
      end
      if (bus.ready_o === 1'b1) begin
        ok   = 1'b1;
        got  = bus.result_o;
        took = cyc - exp_e0;
      end
    end
    bus.start_i = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout cycle %0d: got no ready expected ready within 80 cycles", cyc);
    end
    tick();
    hold_res   = exp_res;
    exp_active = 1'b0;
  endtask

  task automatic directed(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] lit_res, input int lit_lat);
    logic [63:0] got;
    int          took;
    run_div(s, a, b, 1'b0, got, took);
    chk({name, "_result"}, got, lit_res);
    chk({name, "_latency"}, 64'(took), 64'(lit_lat));
  endtask

  initial begin : main_p
    logic [63:0] got;
    int          took;
    logic [31:0] a, b;
    logic        s;
    int          early_lat;

    rst            = 1'b1;
    bus.start_i    = 1'b0;
    bus.annul_i    = 1'b0;
    bus.signed_i   = 1'b0;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    repeat (3) tick();
    rst = 1'b0;
    hold_res = '0;
    chk("reset_result", bus.result_o, 64'd0);
    chk("reset_ready", {63'd0, bus.ready_o}, 64'd0);
    chk("reset_busy", {63'd0, bus.busy_o}, 64'd0);
    chk_en = 1'b1;
    tick();

    directed("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
    directed("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33);
    directed("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
    directed("divu_by_zero", 1'b0, 32'h12345678, 32'd0, 64'd0, 2);
    directed("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);

    // annul mid-RUN: no ready, result unchanged, immediate restart works
    launch(1'b1, 32'd1000, 32'd3);
    repeat (11) tick();
    bus.annul_i = 1'b1;
    tick();
    exp_active  = 1'b0;
    bus.annul_i = 1'b0;
    directed("divu_9_3_after_annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

    // annul during ZERO
    launch(1'b0, 32'd5, 32'd0);
    tick();
    bus.annul_i = 1'b1;
    tick();
    exp_active  = 1'b0;
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    tick();

    // annul in IDLE blocks a start
    bus.start_i    = 1'b1;
    bus.annul_i    = 1'b1;
    bus.dividend_i = 32'd50;
    bus.divisor_i  = 32'd5;
    repeat (3) tick();
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    tick();

`ifdef DIV_EARLY_OUT_EN
    early_lat = 1;
`else
    early_lat = 33;
`endif
    directed("divu_5_9", 1'b0, 32'd5, 32'd9, 64'h00000005_00000000, early_lat);
    directed("div_m3_5", 1'b1, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFD_00000000, early_lat);

    // reset mid-RUN with start held through reset
    launch(1'b0, 32'hDEADBEEF, 32'd17);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    exp_active = 1'b0;
    hold_res   = '0;
    repeat (3) tick();
    bus.start_i = 1'b0;
    rst = 1'b0;
    tick();

    for (int n = 0; n < 60; n++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin s = 1'b1; a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: a = 32'($urandom_range(0, 20)) - 32'd10;
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_div(s, a, b, 1'b1, got, took);
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cycle %0d: got no completion expected finish before time limit", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Multi-cycle radix-2 restoring divider in the execute stage; implements MIPS DIV and DIVU.
- Consumes `div_start` from the hazard unit on `start_i` and returns `div_ready` on `ready_o`.
- Writes the 64-bit {HI, LO} result towards the HI/LO register path.
- While a division is in flight, the hazard unit holds the IF/ID/EX/MEM stages stalled.

Parameters:
- DW, 32, operand width; quotient and remainder are each DW bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DW.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start_i  input  1  division request (level), from the hazard unit's `div_start`.
- signed_i  input  1  1 = DIV (signed), 0 = DIVU.
- dividend_i  input  DW  rs operand from execute.
- divisor_i  input  DW  rt operand from execute.
- annul_i  input  1  abort the current operation (exception flush from the MEM stage).
- result_o  output  2*DW  {remainder (HI), quotient (LO)}.
- ready_o  output  1  result valid, to the hazard unit's `div_ready`.
- busy_o  output  1  operation in progress (debug/perf).

Behaviour:
- Reset: state=IDLE, counter=0, result_o=0, ready_o=0, busy_o=0. Reset mid-operation discards everything and returns to IDLE on the next edge.
- States: IDLE, ZERO, RUN, DONE. Outputs are registered; busy_o=1 in ZERO and RUN.
- IDLE:
  - start_i=1 and annul_i=0 → latch operands and signed_i.
  - Divisor==0 → ZERO; otherwise → RUN with counter=0.
  - When signed_i=1, negative operands are converted to magnitudes (two's complement), and the result signs are recorded.
- RUN, one iteration per cycle:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor magnitude using a DW+1-bit subtractor.
  - If the difference is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - After DW iterations (counter==DW-1) → DONE.
  - Sign fix applied on entry to DONE:
    - Quotient is negated if the operand signs differ (signed only).
    - Remainder is negated if the dividend was negative (signed only).
  - 0x80000000 / -1 (signed) yields quotient 0x80000000, remainder 0; no trap.
- ZERO: one cycle, then → DONE with result_o=0 (HI=0, LO=0). Division by zero produces no exception.
- DONE:
  - ready_o=1 and result_o holds the final value.
  - Stays in DONE while start_i=1 and annul_i=0.
  - Leaves for IDLE when start_i=0 or annul_i=1.
  - The hazard unit drops start_i combinationally once ready_o=1, so ready_o is normally a 1-cycle pulse.
- Latency: with start_i sampled high at edge E0, ready_o rises after edge E0+DW+1 (33 cycles for DW=32). Divide-by-zero: ready_o rises after edge E0+2.
- annul_i:
  - Has priority over start_i in every state.
  - In ZERO, RUN or DONE → IDLE next edge, ready_o=0; result_o keeps its prior value and is not valid.
  - In IDLE it blocks a start.
- result_o changes only on entry to DONE, so it is stable until the next accepted start.
- Operands are sampled only in IDLE; changes on dividend_i/divisor_i during RUN are ignored.
- A new start_i in the cycle after DONE→IDLE is accepted normally (back-to-back divides).

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, if divisor magnitude > dividend magnitude (divisor non-zero) → skip directly to DONE.
  - Quotient 0; remainder = original dividend (sign preserved).
  - ready_o rises after edge E0+1.
  - The magnitude comparator is added to IDLE decode.
- Undefined: every non-zero-divisor operation takes the full DW+1-cycle latency; no comparator is synthesised.

Test Plan:
- DIVU 100/7, start held until ready → ready_o 1 cycle at E0+33; result_o HI=0x00000002, LO=0x0000000E; then IDLE.
- DIV -7/2 (0xFFFFFFF9, 2) → HI=0xFFFFFFFF (-1), LO=0xFFFFFFFD (-3); DIV 7/-2 → HI=1, LO=0xFFFFFFFD.
- DIVU 0x12345678/0 → ready at E0+2, result_o=0; signed 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- annul_i pulsed at RUN iteration 10 of DIV 1000/3 → IDLE next edge, ready_o never asserts; an immediate DIVU 9/3 then completes with LO=3, HI=0 at +33.
- rst asserted mid-RUN → next edge: ready_o=0, busy_o=0, result_o=0; start_i held for 3 cycles during reset is ignored.
- With DIV_EARLY_OUT_EN: DIVU 5/9 → ready at E0+1, HI=5, LO=0; without it the same result arrives at E0+33.
